mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_timer.sv | 37 +++
 rtl/mem_arb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================
// Module : mem_arb_pkg
// Shared arbiter state encoding and timeout counter width.
// Rev    : 1.0
// ============================================================
package mem_arb_pkg;

  localparam int ARB_TIMEOUT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DATA  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/arb_timer.sv
`default_nettype none
// ============================================================
// Module : arb_timer
// Ack wait counter; flags expiry after TIMEOUT_CYCLES cycles without ack.
// Rev    : 1.0
// ============================================================
module arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_ack,
  output logic o_expired
);

  localparam logic [ARB_TIMEOUT_W-1:0] c_LIMIT = ARB_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [ARB_TIMEOUT_W-1:0] r_cnt;

  // The last counted cycle is the expiry cycle, so the request is held TIMEOUT_CYCLES cycles.
  assign o_expired = ~i_clr & ~i_ack & (r_cnt == c_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!i_ack && !o_expired) begin
      r_cnt <= r_cnt + ARB_TIMEOUT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================
// Module : mem_arb
// Fetch/data arbiter onto one shared memory port; optional ack timeout
// enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                dm_req_i,
  input  logic                dm_wren_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_bmask_i,
  input  logic                flush_i,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                mem_req_o,
  output logic                mem_wren_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_bmask_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_valid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_valid_o,
  output logic                if_stall_o,
  output logic                dm_stall_o,
  output logic                err_o
);

  arb_state_e            r_state;
  logic                  r_mem_req;
  logic                  r_mem_wren;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W/8-1:0]   r_mem_bmask;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_dm_rdata;
  logic                  r_if_valid;
  logic                  r_dm_valid;
  logic                  w_timeout;
  logic                  w_done;

`ifdef MEM_ARB_TIMEOUT_EN
  logic w_tmr_clr;
  logic r_err;

  // Counter restarts on every entry into a waiting state, including FETCH -> DRAIN.
  assign w_tmr_clr = (r_state == ST_IDLE) || (r_state == ST_RESP) ||
                     ((r_state == ST_FETCH) && flush_i);

  arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_arb_timer (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .i_clr     (w_tmr_clr),
    .i_ack     (mem_ack_i),
    .o_expired (w_timeout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  assign w_done = mem_ack_i | w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_wren  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_bmask <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dm_req_i) begin
            r_mem_req   <= 1'b1;
            r_mem_wren  <= dm_wren_i;
            r_mem_addr  <= dm_addr_i;
            r_mem_wdata <= dm_wdata_i;
            r_mem_bmask <= dm_bmask_i;
            r_state     <= ST_DATA;
          end else if (if_req_i && !flush_i) begin
            r_mem_req   <= 1'b1;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= if_addr_i;
            r_mem_wdata <= '0;
            r_mem_bmask <= '1;
            r_state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (flush_i) begin
            // An ack arriving with the flush already retires the access.
            if (mem_ack_i) begin
              r_mem_req <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_state   <= ST_DRAIN;
            end
          end else if (w_done) begin
            r_mem_req  <= 1'b0;
            r_if_rdata <= w_timeout ? '0 : mem_rdata_i;
            r_if_valid <= 1'b1;
            r_state    <= ST_RESP;
          end
        end
        ST_DATA: begin
          if (w_done) begin
            r_mem_req  <= 1'b0;
            r_dm_valid <= 1'b1;
            if (!r_mem_wren) begin
              r_dm_rdata <= w_timeout ? '0 : mem_rdata_i;
            end
            r_state    <= ST_RESP;
          end
        end
        ST_DRAIN: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_RESP: begin
          r_if_valid <= 1'b0;
          r_dm_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_mem_req  <= 1'b0;
          r_if_valid <= 1'b0;
          r_dm_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_wren_o  = r_mem_wren;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_bmask_o = r_mem_bmask;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign dm_valid_o  = r_dm_valid;
  // A flush during the fetch response cycle squashes the instruction.
  assign if_valid_o  = r_if_valid & ~flush_i;

  assign dm_stall_o  = dm_req_i & ~dm_valid_o;
  assign if_stall_o  = (if_req_i & ~if_valid_o) | dm_stall_o;

endmodule
`default_nettype wire
